// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: tag allocation at dispatch, CDB result capture,
// operand forwarding to dispatch and in-order retirement. Entry i owns tag i+1; tag 0 means "no tag".
module reorder_buffer #(
   parameter int ROB_SZ    = 8,
   parameter int XLEN      = 32,
   parameter int REG_IDX_W = 5,
   parameter int TAG_W     = $clog2(ROB_SZ) + 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 dispatch_valid,
   input  logic [REG_IDX_W-1:0] dispatch_dest_reg,
   input  logic [TAG_W-1:0]     rs1_tag_in,
   input  logic [TAG_W-1:0]     rs2_tag_in,
   input  logic                 cdb_valid,
   input  logic [TAG_W-1:0]     cdb_tag,
   input  logic [XLEN-1:0]      cdb_value,
   input  logic                 squash,
   output logic [TAG_W-1:0]     rob_entry_out,
   output logic [XLEN-1:0]      rs1_value_out,
   output logic [XLEN-1:0]      rs2_value_out,
   output logic                 full,
   output logic [TAG_W-1:0]     count,
   output logic                 retire_valid,
   output logic [TAG_W-1:0]     retire_tag,
   output logic [REG_IDX_W-1:0] retire_dest_reg,
   output logic [XLEN-1:0]      retire_value
);

   localparam int IDX_W = $clog2(ROB_SZ);

   logic [ROB_SZ-1:0]    busy_q, busy_d;
   logic [ROB_SZ-1:0]    complete_q, complete_d;
   logic [IDX_W-1:0]     head_q, head_d;
   logic [IDX_W-1:0]     tail_q, tail_d;
   logic [TAG_W-1:0]     count_q, count_d;
   logic [REG_IDX_W-1:0] dest_q  [ROB_SZ];
   logic [XLEN-1:0]      value_q [ROB_SZ];

   logic                 dispatch_acc;
   logic                 cdb_hit;
   logic [IDX_W-1:0]     cdb_idx;
   logic [IDX_W-1:0]     rs1_idx;
   logic [IDX_W-1:0]     rs2_idx;

   assign cdb_idx = cdb_tag[IDX_W-1:0] - IDX_W'(1);
   assign rs1_idx = rs1_tag_in[IDX_W-1:0] - IDX_W'(1);
   assign rs2_idx = rs2_tag_in[IDX_W-1:0] - IDX_W'(1);

   assign full         = (count_q == TAG_W'(ROB_SZ));
   assign count        = count_q;
   assign dispatch_acc = dispatch_valid && !full;
   assign cdb_hit      = cdb_valid && (cdb_tag != '0) && busy_q[cdb_idx];
   assign retire_valid = busy_q[head_q] && complete_q[head_q];

   assign rob_entry_out   = TAG_W'(tail_q) + TAG_W'(1);
   // Retire payload is zeroed when idle so that reset and empty states read as all-zero.
   assign retire_tag      = retire_valid ? TAG_W'(head_q) + TAG_W'(1) : '0;
   assign retire_dest_reg = retire_valid ? dest_q[head_q] : '0;
   assign retire_value    = retire_valid ? value_q[head_q] : '0;

   // CDB bypass takes precedence over the stored value so a result produced this cycle is seen.
   assign rs1_value_out = (rs1_tag_in == '0)                   ? '0        :
                          (cdb_valid && cdb_tag == rs1_tag_in) ? cdb_value :
                                                                 value_q[rs1_idx];
   assign rs2_value_out = (rs2_tag_in == '0)                   ? '0        :
                          (cdb_valid && cdb_tag == rs2_tag_in) ? cdb_value :
                                                                 value_q[rs2_idx];

   always_comb begin
      busy_d     = busy_q;
      complete_d = complete_q;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      if (squash) begin
         busy_d     = '0;
         complete_d = '0;
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
      end else begin
         if (dispatch_acc) begin
            busy_d[tail_q]     = 1'b1;
            complete_d[tail_q] = 1'b0;
            tail_d             = tail_q + IDX_W'(1);
         end
         if (cdb_hit) begin
            complete_d[cdb_idx] = 1'b1;
         end
         if (retire_valid) begin
            busy_d[head_q] = 1'b0;
            head_d         = head_q + IDX_W'(1);
         end
         count_d = count_q + TAG_W'(dispatch_acc) - TAG_W'(retire_valid);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         busy_q     <= '0;
         complete_q <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
      end else begin
         busy_q     <= busy_d;
         complete_q <= complete_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
      end
   end

   // Payload storage needs no reset: busy/complete gate every use of it.
   always_ff @(posedge clock) begin
      if (dispatch_acc && !squash) begin
         dest_q[tail_q] <= dispatch_dest_reg;
      end
      if (cdb_hit && !squash) begin
         value_q[cdb_idx] <= cdb_value;
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: dispatch/full, CDB capture, bypass, in-order retire,
// squash, pointer wrap-around and asynchronous reset.
module tb_reorder_buffer;

   localparam int ROB_SZ    = 8;
   localparam int XLEN      = 32;
   localparam int REG_IDX_W = 5;
   localparam int TAG_W     = 4;

   logic                 clock = 1'b0;
   logic                 reset;
   logic                 dispatch_valid;
   logic [REG_IDX_W-1:0] dispatch_dest_reg;
   logic [TAG_W-1:0]     rs1_tag_in;
   logic [TAG_W-1:0]     rs2_tag_in;
   logic                 cdb_valid;
   logic [TAG_W-1:0]     cdb_tag;
   logic [XLEN-1:0]      cdb_value;
   logic                 squash;
   logic [TAG_W-1:0]     rob_entry_out;
   logic [XLEN-1:0]      rs1_value_out;
   logic [XLEN-1:0]      rs2_value_out;
   logic                 full;
   logic [TAG_W-1:0]     count;
   logic                 retire_valid;
   logic [TAG_W-1:0]     retire_tag;
   logic [REG_IDX_W-1:0] retire_dest_reg;
   logic [XLEN-1:0]      retire_value;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   reorder_buffer #(
      .ROB_SZ(ROB_SZ), .XLEN(XLEN), .REG_IDX_W(REG_IDX_W), .TAG_W(TAG_W)
   ) dut (
      .clock(clock), .reset(reset),
      .dispatch_valid(dispatch_valid), .dispatch_dest_reg(dispatch_dest_reg),
      .rs1_tag_in(rs1_tag_in), .rs2_tag_in(rs2_tag_in),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .squash(squash),
      .rob_entry_out(rob_entry_out), .rs1_value_out(rs1_value_out), .rs2_value_out(rs2_value_out),
      .full(full), .count(count),
      .retire_valid(retire_valid), .retire_tag(retire_tag),
      .retire_dest_reg(retire_dest_reg), .retire_value(retire_value)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      dispatch_valid = 0; dispatch_dest_reg = '0;
      rs1_tag_in = '0; rs2_tag_in = '0;
      cdb_valid = 0; cdb_tag = '0; cdb_value = '0;
      squash = 0;
   endtask

   task automatic check_retire(input string tag, input logic v, input int t, input int d, input int val);
      check({tag, ".valid"}, 64'(retire_valid), 64'(v));
      check({tag, ".tag"},   64'(retire_tag),   64'(t));
      check({tag, ".dest"},  64'(retire_dest_reg), 64'(d));
      check({tag, ".value"}, 64'(retire_value), 64'(val));
   endtask

   initial begin
      idle_inputs();
      reset = 0;
      #1;
      check("rst.count", 64'(count), 0);
      check("rst.full", 64'(full), 0);
      check("rst.entry", 64'(rob_entry_out), 1);
      check_retire("rst.ret", 0, 0, 0, 0);
      repeat (2) @(posedge clock);
      #3 reset = 1;
      step();

      // Fill the ROB: dest r1..r8
      for (int i = 0; i < ROB_SZ; i++) begin
         dispatch_valid = 1; dispatch_dest_reg = REG_IDX_W'(i + 1);
         #1;
         check($sformatf("fill%0d.entry", i), 64'(rob_entry_out), 64'(i + 1));
         step();
      end
      check("fill.count", 64'(count), 8);
      check("fill.full", 64'(full), 1);

      // 9th dispatch is ignored
      dispatch_valid = 1; dispatch_dest_reg = 5'd9;
      step();
      check("ovf.count", 64'(count), 8);
      check("ovf.entry", 64'(rob_entry_out), 1);

      // Complete tag 2 first: no retire
      dispatch_valid = 0;
      cdb_valid = 1; cdb_tag = 4'd2; cdb_value = 32'd10;
      #1;
      check("cdb2.noret", 64'(retire_valid), 0);
      step();
      check("after2.noret", 64'(retire_valid), 0);
      cdb_tag = 4'd1; cdb_value = 32'd7;
      #1;
      check("cdb1.noret", 64'(retire_valid), 0);
      step();

      // Head complete while full, dispatch attempted: retire wins, dispatch rejected
      cdb_valid = 0;
      dispatch_valid = 1; dispatch_dest_reg = 5'd15;
      #1;
      check_retire("ret1", 1, 1, 1, 7);
      check("ret1.full", 64'(full), 1);
      step();
      check("ret1.count", 64'(count), 7);
      check("ret1.fulldrop", 64'(full), 0);
      check("ret1.entry", 64'(rob_entry_out), 1);

      // Retire tag 2 while exercising operand read paths
      dispatch_valid = 0;
      cdb_valid = 1; cdb_tag = 4'd3; cdb_value = 32'd13;
      rs1_tag_in = 4'd3; rs2_tag_in = 4'd2;
      #1;
      check_retire("ret2", 1, 2, 2, 10);
      check("byp.rs1", 64'(rs1_value_out), 13);
      check("stored.rs2", 64'(rs2_value_out), 10);
      rs2_tag_in = 4'd0;
      #1;
      check("tag0.rs2", 64'(rs2_value_out), 0);
      step();
      check("ret2.count", 64'(count), 6);

      // Tag 3 captured; CDB to non-busy entry 0 is ignored
      cdb_valid = 1; cdb_tag = 4'd1; cdb_value = 32'd99;
      rs1_tag_in = 4'd3;
      #1;
      check_retire("ret3", 1, 3, 3, 13);
      step();
      cdb_valid = 0;
      #1;
      check("stored.rs1", 64'(rs1_value_out), 13);
      check("ret3.count", 64'(count), 5);
      check("head4.noret", 64'(retire_valid), 0);

      // Squash with dispatch and CDB active
      squash = 1; dispatch_valid = 1; dispatch_dest_reg = 5'd21;
      cdb_valid = 1; cdb_tag = 4'd4; cdb_value = 32'd5;
      step();
      idle_inputs();
      #1;
      check("sq.count", 64'(count), 0);
      check("sq.entry", 64'(rob_entry_out), 1);
      check("sq.full", 64'(full), 0);
      check("sq.noret", 64'(retire_valid), 0);

      // Head restarts at entry 0 after squash
      dispatch_valid = 1; dispatch_dest_reg = 5'd20;
      step();
      dispatch_valid = 0;
      check("sq.disp.count", 64'(count), 1);
      check("sq.disp.entry", 64'(rob_entry_out), 2);
      cdb_valid = 1; cdb_tag = 4'd1; cdb_value = 32'd42;
      step();
      cdb_valid = 0;
      #1;
      check_retire("sq.ret", 1, 1, 20, 42);
      step();
      check("sq.empty", 64'(count), 0);
      squash = 1;
      step();
      squash = 0;

      // Wrap-around pipeline: dispatch k, complete k-1, retire k-2
      for (int cyc = 0; cyc < 22; cyc++) begin
         dispatch_valid = (cyc < 20);
         dispatch_dest_reg = REG_IDX_W'(cyc);
         cdb_valid = (cyc >= 1 && cyc <= 20);
         cdb_tag = TAG_W'(((cyc - 1) % 8) + 1);
         cdb_value = XLEN'(100 + cyc - 1);
         #1;
         if (cyc >= 2)
            check_retire($sformatf("wrap%0d", cyc), 1, ((cyc - 2) % 8) + 1, cyc - 2, 100 + cyc - 2);
         else
            check($sformatf("wrap%0d.noret", cyc), 64'(retire_valid), 0);
         step();
      end
      idle_inputs();
      #1;
      check("wrap.count", 64'(count), 0);

      // Asynchronous reset mid-run with three busy entries
      for (int i = 0; i < 3; i++) begin
         dispatch_valid = 1; dispatch_dest_reg = REG_IDX_W'(i + 1);
         step();
      end
      dispatch_valid = 0;
      check("pre.count", 64'(count), 3);
      #2 reset = 0;
      #1;
      check("arst.count", 64'(count), 0);
      check("arst.full", 64'(full), 0);
      check("arst.noret", 64'(retire_valid), 0);
      check("arst.entry", 64'(rob_entry_out), 1);
      #3 reset = 1;
      step();
      check("post.count", 64'(count), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
